// File: rtl/rapcla_pkg.sv
`default_nettype none
// ============================================================================
// Module : rapcla_pkg
// Brief  : Shared mode/state encodings and sizing helper for RAPCLA control.
// Rev    : 1.0
// ============================================================================
package rapcla_pkg;

  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_APPROX = 2'd1;
  localparam logic [1:0] MODE_ADAPT  = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  function automatic int ng_of(input int size, input int groupsize);
    return size / groupsize;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rapcla_accuracy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : rapcla_accuracy_ctrl_if
// Brief  : Request/result valid-ready streams of the RAPCLA controller.
// Rev    : 1.0
// ============================================================================
interface rapcla_accuracy_ctrl_if #(
  parameter int SIZE = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_a;
  logic [SIZE-1:0] in_b;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_sum;
  logic            out_cout;
  logic            out_approx;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_approx
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_approx
  );
endinterface
`default_nettype wire

// File: rtl/rapcla_abs_err.sv
`default_nettype none
// ============================================================================
// Module : rapcla_abs_err
// Brief  : Combinational absolute difference of two unsigned values.
// Rev    : 1.0
// ============================================================================
module rapcla_abs_err #(
  parameter int WIDTH = 17
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] diff
);
  assign diff = (a >= b) ? (a - b) : (b - a);
endmodule
`default_nettype wire

// File: rtl/rapcla_accuracy_ctrl.sv
`default_nettype none
// ============================================================================
// Module : rapcla_accuracy_ctrl
// Brief  : Sequences add requests onto an external RAPCLA and adapts the
//          number of approximated groups from periodic exact re-runs.
// Rev    : 1.0
// ============================================================================
module rapcla_accuracy_ctrl
  import rapcla_pkg::*;
#(
  parameter int  SIZE         = 16,
  parameter int  GROUPSIZE    = 8,
  parameter int  CHECK_PERIOD = 16,
  localparam int NG           = ng_of(SIZE, GROUPSIZE),
  localparam int LW           = $clog2(NG + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  rapcla_accuracy_ctrl_if.slave  bus,
  input  wire logic [1:0]        cfg_mode,
  input  wire logic [SIZE:0]     cfg_err_thresh,
  output logic      [SIZE-1:0]   add_a,
  output logic      [SIZE-1:0]   add_b,
  output logic                   add_cin,
  output logic      [NG-1:0]     add_rcon,
  input  wire logic [SIZE-1:0]   add_sum,
  input  wire logic              add_cout,
  output logic      [LW-1:0]     level,
  output logic      [15:0]       err_count
);
  localparam int CW = $clog2(CHECK_PERIOD);

  logic [1:0]      r_state;
  logic [SIZE-1:0] r_a, r_b, r_sum;
  logic            r_cin, r_cout, r_approx;
  logic [1:0]      r_mode;
  logic [SIZE:0]   r_thresh;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_level;
  logic [15:0]     r_err_count;

  logic [NG-1:0]   w_lvl_mask;
  logic [NG-1:0]   w_mask;
  logic [SIZE:0]   w_err;
  logic            w_adapt;
  logic            w_cnt_last;

  // Low groups are approximated first: level L sets rcon bits [L-1:0].
  always_comb begin
    w_lvl_mask = '0;
    w_mask     = '0;
    for (int i = 0; i < NG; i++) begin
      w_lvl_mask[i] = (i < int'(r_level));
    end
    case (r_mode)
      MODE_APPROX: w_mask = '1;
      MODE_ADAPT:  w_mask = w_lvl_mask;
      default:     w_mask = '0;
    endcase
  end

  assign w_adapt    = (r_mode == MODE_ADAPT);
  assign w_cnt_last = (r_cnt == CW'(CHECK_PERIOD - 1));

  rapcla_abs_err #(.WIDTH(SIZE + 1)) u_abs_err (
    .a    ({r_cout, r_sum}),
    .b    ({add_cout, add_sum}),
    .diff (w_err)
  );

  assign add_a    = r_a;
  assign add_b    = r_b;
  assign add_cin  = r_cin;
  assign add_rcon = (r_state == ST_ISSUE) ? w_mask : '0;

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_HOLD);
  assign bus.out_sum    = r_sum;
  assign bus.out_cout   = r_cout;
  assign bus.out_approx = r_approx;
  assign level          = r_level;
  assign err_count      = r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_mode      <= MODE_EXACT;
      r_thresh    <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_approx    <= 1'b0;
      r_cnt       <= '0;
      r_level     <= LW'(NG);
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_cin    <= bus.in_cin;
            r_mode   <= cfg_mode;
            r_thresh <= cfg_err_thresh;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_sum    <= add_sum;
          r_cout   <= add_cout;
          r_approx <= |w_mask;
          if (w_adapt) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
          end
          // With level 0 the mask is empty, so the period passes without a check.
          r_state <= (w_adapt && w_cnt_last && (|w_mask)) ? ST_CHECK : ST_HOLD;
        end
        ST_CHECK: begin
          r_sum    <= add_sum;
          r_cout   <= add_cout;
          r_approx <= 1'b0;
          if (w_err > r_thresh) begin
            if (r_level != '0) r_level <= r_level - LW'(1);
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end else if ((w_err == '0) && (r_level != LW'(NG))) begin
            r_level <= r_level + LW'(1);
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rapcla_accuracy_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_rapcla_accuracy_ctrl
// Brief  : Self-checking bench with a transaction-level accuracy model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rapcla_accuracy_ctrl;
  localparam int SIZE = 16;
  localparam int GS   = 8;
  localparam int NG   = 2;
  localparam int P    = 4;
  localparam int LW   = 2;
  localparam int WIN  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      cfg_mode = 2'd0;
  logic [SIZE:0]   cfg_err_thresh = '0;
  logic [SIZE-1:0] add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic [NG-1:0]   add_rcon;
  logic [LW-1:0]   level;
  logic [15:0]     err_count;

  always #5 clk = ~clk;

  rapcla_accuracy_ctrl_if #(.SIZE(SIZE)) bus ();

  rapcla_accuracy_ctrl #(.SIZE(SIZE), .GROUPSIZE(GS), .CHECK_PERIOD(P)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .cfg_mode       (cfg_mode),
    .cfg_err_thresh (cfg_err_thresh),
    .add_a          (add_a),
    .add_b          (add_b),
    .add_cin        (add_cin),
    .add_rcon       (add_rcon),
    .add_sum        (add_sum),
    .add_cout       (add_cout),
    .level          (level),
    .err_count      (err_count)
  );

  // RAPCLA stand-in: an approximated group predicts its carry-out from its top WIN bits only.
  function automatic logic [16:0] rapcla(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic [1:0] rcon);
    logic [16:0] r;
    logic [8:0]  s;
    logic [4:0]  w;
    logic        c;
    c = cin;
    r = '0;
    for (int g = 0; g < NG; g++) begin
      s = {1'b0, a[g*GS +: GS]} + {1'b0, b[g*GS +: GS]} + {8'd0, c};
      r[g*GS +: GS] = s[7:0];
      w = {1'b0, a[g*GS+GS-WIN +: WIN]} + {1'b0, b[g*GS+GS-WIN +: WIN]};
      c = rcon[g] ? w[4] : s[8];
    end
    r[16] = c;
    return r;
  endfunction

  always_comb {add_cout, add_sum} = rapcla(add_a, add_b, add_cin, add_rcon);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  int          m_level = NG;
  int          m_cnt   = 0;
  int          m_errc  = 0;
  logic [15:0] exp_sum = '0;
  logic        exp_cout = 1'b0;
  logic        exp_approx = 1'b0;
  int          exp_level = NG;
  int          exp_errc = 0;

  function automatic logic [1:0] mask_of(input logic [1:0] mode, input int lvl);
    if (mode == 2'd1) return 2'b11;
    if (mode == 2'd2) return 2'((1 << lvl) - 1);
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("out_sum",  bus.out_sum,  exp_sum);
      chk("out_cout", bus.out_cout, exp_cout);
      chk("out_approx", bus.out_approx, exp_approx);
      chk("level", level, exp_level);
      chk("err_count", err_count, exp_errc);
      chk("in_ready_busy", bus.in_ready, 0);
    end
  end

  task automatic run_txn(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [16:0] th, input int hold,
                         input bit keep_valid, input bit rst_in_check,
                         output logic [17:0] res, output int lat);
    logic [16:0] ex, ap, err;
    logic [1:0]  rc;
    bit          is_check, seen;
    int          n, exp_lat;
    res = '0;
    lat = -1;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
    cfg_mode = mode;
    cfg_err_thresh = th;
    rc = mask_of(mode, m_level);
    ex = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ap = rapcla(a, b, cin, rc);
    is_check = (mode == 2'd2) && (m_cnt == P - 1) && (rc != 2'b00);
    if (mode == 2'd2) m_cnt = (m_cnt + 1) % P;
    if (is_check) begin
      err = (ap > ex) ? ap - ex : ex - ap;
      if (err > th) begin
        if (m_level > 0) m_level--;
        if (m_errc < 65535) m_errc++;
      end else if (err == 0 && m_level < NG) begin
        m_level++;
      end
      {exp_cout, exp_sum} = ex;
      exp_approx = 1'b0;
      exp_lat = 3;
    end else begin
      {exp_cout, exp_sum} = ap;
      exp_approx = (rc != 2'b00);
      exp_lat = 2;
    end
    exp_level = m_level;
    exp_errc = m_errc;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) bus.in_valid = 1'b0;
    chk("add_rcon", add_rcon, rc);
    chk("add_ops", {add_cin, add_a, add_b}, {cin, a, b});
    cfg_mode = 2'($urandom);
    cfg_err_thresh = 17'($urandom);
    n = 1;
    seen = 0;
    while (!seen && n < 8) begin
      if (rst_in_check && n == 2) begin
        chk("check_no_valid", bus.out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_level", level, NG);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        m_level = NG; m_cnt = 0; m_errc = 0;
        exp_level = NG; exp_errc = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        return;
      end
      if (bus.out_valid) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      chk("out_valid_timeout", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      return;
    end
    chk("latency", n, exp_lat);
    lat = n;
    res = {bus.out_approx, bus.out_cout, bus.out_sum};
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_after_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] res;
    int          lat;
    logic [15:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out", {bus.out_approx, bus.out_cout, bus.out_sum}, 0);
    chk("reset_level", level, NG);
    chk("reset_err_count", err_count, 0);
    chk("reset_add", {add_rcon, add_cin, add_a, add_b}, 0);
    rst_n = 1'b1;

    // Exact and all-approximate on a carry across the group boundary
    run_txn(2'd0, 16'h00FF, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    chk("lit_exact", res, 18'h00100);
    chk("lit_exact_lat", lat, 2);
    run_txn(2'd1, 16'h00FF, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    chk("lit_approx", res, 18'h20000);

    // Fourth adaptive op lands on a check with err = 256
    repeat (3) run_txn(2'd2, 16'h0001, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    run_txn(2'd2, 16'h00FF, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    chk("lit_check_res", res, 18'h00100);
    chk("lit_check_lat", lat, 3);
    chk("lit_level_down", level, 1);
    chk("lit_err_count", err_count, 1);

    // Error-free checks climb back to and saturate at NG
    for (int i = 0; i < 16; i++) begin
      run_txn(2'd2, 16'h0001, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
      if (i == 3) chk("lit_level_up", level, 2);
    end
    chk("lit_level_sat", level, 2);

    // Backpressure with a pending request
    run_txn(2'd0, 16'h1234, 16'h4321, 1'b1, 17'd0, 5, 1, 0, res, lat);
    chk("lit_backpressure", res, 18'h05556);

    // Reset while the exact re-run is in progress
    repeat (3) run_txn(2'd2, 16'h0001, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    run_txn(2'd2, 16'h00FF, 16'h0001, 1'b0, 17'd16, 0, 0, 1, res, lat);
    run_txn(2'd2, 16'h00FF, 16'h0001, 1'b0, 17'd16, 0, 0, 0, res, lat);
    chk("lit_post_rst", res, 18'h20000);
    chk("lit_post_rst_lat", lat, 2);

    for (int i = 0; i < 80; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ra[7:0] = 8'hFF - rb[7:0] + 8'($urandom_range(0, 3));
      run_txn(2'($urandom_range(0, 3)), ra, rb, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 600)),
              $urandom_range(0, 3), 1'($urandom), 0, res, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
